display7seg_scan: RTL and testbench

DISPLAY7SEG_SCAN -- requirements
Module: display7seg_scan

---
 rtl/display7seg_pkg.sv | 54 +++++
 rtl/display7seg_bin2bcd.sv | 108 ++++++++++
 rtl/display7seg_scan.sv | 93 +++++++++
 tb/tb_display7seg_scan.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display7seg_pkg.sv
`default_nettype none
// ============================================================================
// display7seg_pkg : segment patterns, converter states and helper functions
// Revision 1.0
// ============================================================================
package display7seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/display7seg_bin2bcd.sv
`default_nettype none
// ============================================================================
// display7seg_bin2bcd : sequential double-dabble converter, one bit per cycle
// Revision 1.0
// ============================================================================
module display7seg_bin2bcd
    import display7seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    valor,
    input  logic                load,
    output logic                busy,
    output logic [DIGITS*4-1:0] bcd,
    output logic                overflow
);

    localparam int          DW    = DIGITS * 4;
    localparam int          CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [31:0] C_LIMIT = pow10(DIGITS);

    conv_state_t         r_state;
    conv_state_t         w_next;
    logic [WIDTH-1:0]    r_shreg;
    logic [DW-1:0]       r_acc;
    logic [DW-1:0]       w_adj;
    logic [CW-1:0]       r_cnt;
    logic                r_ovf_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_cnt == C_LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Carries only move upward, so keeping just DIGITS nibbles yields valor mod 10^DIGITS
    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_acc[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            bcd        <= '0;
            overflow   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shreg    <= valor;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= (32'(valor) >= C_LIMIT);
                    end
                end
                SHIFT: begin
                    r_acc   <= {w_adj[DW-2:0], r_shreg[WIDTH-1]};
                    r_shreg <= r_shreg << 1;
                    r_cnt   <= r_cnt + 1'b1;
                end
                DONE: begin
                    bcd      <= r_acc;
                    overflow <= r_ovf_pend;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/display7seg_scan.sv
`default_nettype none
// ============================================================================
// display7seg_scan : binary-to-BCD multiplexed 7-segment display driver
// Revision 1.0
// ============================================================================
module display7seg_scan
    import display7seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int WIDTH    = 14,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  valor,
    input  logic              load,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int            SW     = $clog2(SCAN_DIV);
    localparam int            IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SW-1:0] C_SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] C_DIGIT_LAST = IW'(DIGITS - 1);

    logic [DIGITS*4-1:0] w_bcd;
    logic [SW-1:0]       r_scan_cnt;
    logic [IW-1:0]       r_idx;
    logic [6:0]          w_dseg [DIGITS];
    logic                w_lead_zero;

    display7seg_bin2bcd #(
        .DIGITS (DIGITS),
        .WIDTH  (WIDTH)
    ) u_bin2bcd (
        .clk      (clk),
        .reset    (reset),
        .valor    (valor),
        .load     (load),
        .busy     (busy),
        .bcd      (w_bcd),
        .overflow (overflow)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == C_SLOT_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == C_DIGIT_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Walk from the top digit down; a digit is blank while every nibble from the top to it is zero
    always_comb begin
        w_lead_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_dseg[i] = SEG_BLANK;
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (overflow) begin
                w_dseg[i] = SEG_DASH;
            end else if ((BLANK_LZ != 0) && (i != 0) && w_lead_zero
                         && (w_bcd[i*4 +: 4] == 4'd0)) begin
                w_dseg[i] = SEG_BLANK;
            end else begin
                w_dseg[i] = seg_decode(w_bcd[i*4 +: 4]);
            end
            if (w_bcd[i*4 +: 4] != 4'd0) begin
                w_lead_zero = 1'b0;
            end
        end
    end

    always_comb begin
        seg = w_dseg[0];
        for (int i = 1; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                seg = w_dseg[i];
            end
        end
    end

    assign an = ~(DIGITS'(1) << r_idx);

endmodule
`default_nettype wire

// File: tb/tb_display7seg_scan.sv
`default_nettype none
// ============================================================================
// tb_display7seg_scan : directed self-checking bench for display7seg_scan
// Revision 1.0
// ============================================================================
module tb_display7seg_scan;

    localparam int DIGITS   = 4;
    localparam int WIDTH    = 14;
    localparam int SCAN_DIV = 4;

    logic              clk;
    logic              reset;
    logic [WIDTH-1:0]  valor;
    logic              load;
    logic              busy;
    logic              overflow;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    int vectors;
    int miscompares;

    display7seg_scan #(
        .DIGITS   (DIGITS),
        .WIDTH    (WIDTH),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_LZ (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valor    (valor),
        .load     (load),
        .busy     (busy),
        .overflow (overflow),
        .seg      (seg),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for the scan to select digit d and returns its pattern
    task automatic get_digit(input int d, output logic [6:0] s, output bit found);
        logic [3:0] want;
        want  = ~(4'b0001 << d);
        found = 1'b0;
        s     = 7'bxxxxxxx;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (an === want) begin
                s     = seg;
                found = 1'b1;
                break;
            end
        end
    endtask

    // Pulses load for one cycle and counts busy-high samples until busy drops
    task automatic do_load(input logic [WIDTH-1:0] v, output int nb);
        nb    = 0;
        valor = v;
        load  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            load = 1'b0;
            if (busy) nb++;
            else break;
        end
    endtask

    task automatic check_digits(input string name, input logic [6:0] exp [4]);
        logic [6:0] s;
        bit         f;
        for (int d = 0; d < 4; d++) begin
            get_digit(d, s, f);
            vectors++;
            if (!f || s !== exp[d]) begin
                miscompares++;
                $display("FAIL %s digit%0d: seg=%b found=%0d, expected %b", name, d, s, f, exp[d]);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        load  = 1'b0;
        valor = '0;
        #3;
        vectors++;
        if (busy !== 1'b0 || overflow !== 1'b0 || an !== 4'b1110 || seg !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_hold: busy=%b ovf=%b an=%b seg=%b, expected 0 0 1110 1000000",
                     busy, overflow, an, seg);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_scan;
        logic [3:0] exp_an;
        @(negedge clk);
        vectors++;
        if (an !== 4'b1110 || seg !== 7'b1000000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL scan_start: an=%b seg=%b busy=%b, expected 1110 1000000 0", an, seg, busy);
        end
        repeat (3) @(negedge clk);
        for (int k = 1; k < 4; k++) begin
            exp_an = ~(4'b0001 << k);
            vectors++;
            if (an !== exp_an || seg !== 7'b1111111) begin
                miscompares++;
                $display("FAIL scan_rot%0d: an=%b seg=%b, expected %b 1111111", k, an, seg, exp_an);
            end
            repeat (4) @(negedge clk);
        end
        vectors++;
        if (an !== 4'b1110) begin
            miscompares++;
            $display("FAIL scan_wrap: an=%b, expected 1110", an);
        end
    endtask

    task automatic test_load_1234;
        int nb;
        do_load(14'd1234, nb);
        vectors++;
        if (nb != 15) begin
            miscompares++;
            $display("FAIL busy_len_1234: busy cycles=%0d, expected 15", nb);
        end
        check_digits("val_1234", '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001});
    endtask

    task automatic test_small_and_max;
        int nb;
        do_load(14'd7, nb);
        check_digits("val_7", '{7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111});
        do_load(14'd9999, nb);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_9999: overflow=%b, expected 0", overflow);
        end
        check_digits("val_9999", '{7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000});
    endtask

    task automatic test_overflow;
        int nb;
        do_load(14'd10000, nb);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_10000: overflow=%b, expected 1", overflow);
        end
        check_digits("val_10000", '{7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111});
        do_load(14'd5, nb);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear_5: overflow=%b, expected 0", overflow);
        end
        check_digits("val_5", '{7'b0010010, 7'b1111111, 7'b1111111, 7'b1111111});
    endtask

    task automatic test_back_to_back;
        int nb;
        bit restarted;
        nb    = 0;
        valor = 14'd42;
        load  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            load = 1'b0;
            if (busy) begin
                nb++;
                if (nb == 5 || nb == 15) begin
                    valor = 14'd9999;
                    load  = 1'b1;
                end
            end else begin
                break;
            end
        end
        load = 1'b0;
        vectors++;
        if (nb != 15) begin
            miscompares++;
            $display("FAIL busy_len_ignore: busy cycles=%0d, expected 15", nb);
        end
        restarted = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy) restarted = 1'b1;
        end
        vectors++;
        if (restarted) begin
            miscompares++;
            $display("FAIL no_queue: busy rose again=%0d, expected 0", restarted);
        end
        check_digits("val_42", '{7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111});
    endtask

    task automatic test_reset_mid;
        int nb;
        bit bad;
        nb    = 0;
        valor = 14'd1234;
        load  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            load = 1'b0;
            if (busy) nb++;
            if (nb == 6 || !busy) break;
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (nb != 6 || busy !== 1'b0 || an !== 4'b1110 || seg !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_mid: nb=%0d busy=%b an=%b seg=%b, expected 6 0 1110 1000000",
                     nb, busy, an, seg);
        end
        @(negedge clk);
        reset = 1'b1;
        bad   = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0 || overflow !== 1'b0) bad = 1'b1;
            if (an === 4'b1110 && seg !== 7'b1000000) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: busy/overflow/digit0 disturbed=%0d, expected 0", bad);
        end
        check_digits("after_reset", '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset;
        test_scan;
        test_load_1234;
        test_small_and_max;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
